ram512_ctrl: RTL and testbench

Request/acknowledge front end placed directly upstream of the 512 x 16 RAM. It accepts single-word read and write requests from a master, drives the RAM's address, data-in and load pins, and returns registered read data with a valid pulse. An optional post-reset sweep writes a known value to every RAM word before requests are accepted.

---
 rtl/ram512_ctrl.sv | 117 +++++++++++
 tb/tb_ram512_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ram512_ctrl.sv
// Request/acknowledge front end for a 512 x 16 RAM: single-word reads and writes, registered
// read data with a one-cycle valid pulse. Define RAM_CLEAR_EN to add a post-reset clear sweep.
module ram512_ctrl #(
  parameter logic [15:0] CLEAR_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [8:0]  addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic [15:0] rdata,
  output logic        rvalid,
  output logic [8:0]  mem_add,
  output logic [15:0] mem_in,
  output logic        mem_load,
  input  logic [15:0] mem_o
);

`ifdef RAM_CLEAR_EN
  typedef enum logic [1:0] {StClear, StIdle, StAccess} state_e;
  localparam state_e ResetState = StClear;
`else
  typedef enum logic [0:0] {StIdle, StAccess} state_e;
  localparam state_e ResetState = StIdle;
`endif

  state_e      state_q, state_d;
  logic [8:0]  addr_q;
  logic [15:0] wdata_q;
  logic        we_q;
  logic        accept;
  logic        read_done;

  assign accept    = (state_q == StIdle) && req;
  assign read_done = (state_q == StAccess) && !we_q;
  assign ready     = (state_q == StIdle);

`ifdef RAM_CLEAR_EN
  logic [8:0] cnt;

  // Counter wraps 511 -> 0 on the same edge that leaves the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 9'd0;
    end else if (state_q == StClear) begin
      cnt <= cnt + 9'd1;
    end
  end
`else
  logic unused_clear_val;
  assign unused_clear_val = ^CLEAR_VAL;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ResetState;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef RAM_CLEAR_EN
      StClear:  if (cnt == 9'd511) state_d = StIdle;
`endif
      StIdle:   if (req) state_d = StAccess;
      StAccess: state_d = StIdle;
      default:  state_d = ResetState;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 9'd0;
      wdata_q <= 16'd0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      we_q    <= we;
    end
  end

  // rdata only moves on a completed read; writes leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= 16'd0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= read_done;
      if (read_done) begin
        rdata <= mem_o;
      end
    end
  end

  always_comb begin
    mem_add  = addr_q;
    mem_in   = wdata_q;
    mem_load = 1'b0;
`ifdef RAM_CLEAR_EN
    if (state_q == StClear) begin
      mem_add  = cnt;
      mem_in   = CLEAR_VAL;
      mem_load = 1'b1;
    end
`endif
    if (state_q == StAccess) begin
      mem_load = we_q;
    end
  end

endmodule

// File: tb/tb_ram512_ctrl.sv
// Directed bench for ram512_ctrl with a behavioural 512 x 16 RAM attached to the memory pins.
// Covers both builds; RAM_CLEAR_EN selects the clear-sweep expectations.
module tb_ram512_ctrl;
  localparam logic [15:0] CV = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [8:0]  addr = 9'd0;
  logic [15:0] wdata = 16'd0;
  logic        ready;
  logic [15:0] rdata;
  logic        rvalid;
  logic [8:0]  mem_add;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [15:0] mem_o;

  logic [15:0] ram [512];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ram512_ctrl #(.CLEAR_VAL(CV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .mem_add  (mem_add),
    .mem_in   (mem_in),
    .mem_load (mem_load),
    .mem_o    (mem_o)
  );

  always @(posedge clk) begin
    if (mem_load) ram[mem_add] <= mem_in;
  end
  assign mem_o = ram[mem_add];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 1000) begin
      step();
      n++;
    end
    if (!ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [8:0] a, input logic [15:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    wait_ready("wr");
    step();
    req = 1'b0;
    step();
  endtask

  task automatic do_read(input string tag, input logic [8:0] a, input logic [15:0] exp);
    req = 1'b1; we = 1'b0; addr = a;
    wait_ready(tag);
    step();
    req = 1'b0;
    check({tag, "_rvalid_e0"}, {31'd0, rvalid}, 32'd0);
    step();
    check({tag, "_rvalid_e1"}, {31'd0, rvalid}, 32'd1);
    check({tag, "_rdata"}, {16'd0, rdata}, {16'd0, exp});
    step();
    check({tag, "_rvalid_e2"}, {31'd0, rvalid}, 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] old_010;
    for (int i = 0; i < 512; i++) ram[i] = 16'hC000 | 16'(i);

    #12;
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
`ifdef RAM_CLEAR_EN
    check("rst_load", {31'd0, mem_load}, 32'd1);
    check("rst_add", {23'd0, mem_add}, 32'd0);
    check("rst_in", {16'd0, mem_in}, {16'd0, CV});
    check("rst_ready", {31'd0, ready}, 32'd0);
`else
    check("rst_load", {31'd0, mem_load}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
`endif
    step();
    rst_n = 1'b1;

`ifdef RAM_CLEAR_EN
    n = 0;
    while (!ready && n < 600) begin
      step();
      n++;
    end
    check("sweep_len", 32'(n), 32'd512);
    do_read("clr0", 9'd0, CV);
    do_read("clr255", 9'd255, CV);
    do_read("clr511", 9'd511, CV);
    old_010 = CV;
`else
    check("ready_first", {31'd0, ready}, 32'd1);
    do_read("pre0ab", 9'h0AB, 16'hC0AB);
    do_read("pre000", 9'h000, 16'hC000);
    old_010 = 16'hC010;
`endif

    do_write(9'h1FF, 16'h1234);
    do_read("wr1ff", 9'h1FF, 16'h1234);

    // Streamed writes then reads with req held: accepts must land every second edge.
    req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; addr = 9'(i); wdata = 16'(i);
      check("bb_wr_ready", {31'd0, ready}, 32'd1);
      step();
      check("bb_wr_busy", {31'd0, ready}, 32'd0);
      check("bb_wr_load", {31'd0, mem_load}, 32'd1);
      check("bb_wr_add", {23'd0, mem_add}, 32'(i));
      step();
    end
    for (int i = 0; i < 8; i++) begin
      we = 1'b0; addr = 9'(i);
      check("bb_rd_ready", {31'd0, ready}, 32'd1);
      step();
      check("bb_rd_rvalid0", {31'd0, rvalid}, 32'd0);
      step();
      check("bb_rd_rvalid1", {31'd0, rvalid}, 32'd1);
      check("bb_rd_data", {16'd0, rdata}, 32'(i));
    end
    req = 1'b0;
    step();

    // A write request raised during a read access must wait and not pulse mem_load early.
    req = 1'b1; we = 1'b0; addr = 9'h1FF;
    step();
    we = 1'b1; addr = 9'h020; wdata = 16'h7777;
    check("blk_busy", {31'd0, ready}, 32'd0);
    check("blk_noload", {31'd0, mem_load}, 32'd0);
    step();
    check("blk_rvalid", {31'd0, rvalid}, 32'd1);
    check("blk_rdata", {16'd0, rdata}, 32'h1234);
    check("blk_idle_noload", {31'd0, mem_load}, 32'd0);
    check("blk_ready", {31'd0, ready}, 32'd1);
    step();
    check("blk_acc_load", {31'd0, mem_load}, 32'd1);
    check("blk_acc_add", {23'd0, mem_add}, 32'h020);
    req = 1'b0;
    step();
    do_read("blk020", 9'h020, 16'h7777);

    // Reset dropped in the middle of a write access.
    req = 1'b1; we = 1'b1; addr = 9'h010; wdata = 16'hBEEF;
    wait_ready("rw");
    step();
    req = 1'b0;
    check("rw_load_pre", {31'd0, mem_load}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
`ifdef RAM_CLEAR_EN
    check("rw_load", {31'd0, mem_load}, 32'd1);
    check("rw_add", {23'd0, mem_add}, 32'd0);
`else
    check("rw_load", {31'd0, mem_load}, 32'd0);
`endif
    check("rw_rdata", {16'd0, rdata}, 32'd0);
    check("rw_rvalid", {31'd0, rvalid}, 32'd0);
    step();
    rst_n = 1'b1;
    do_read("rw010", 9'h010, old_010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
